// File: rtl/reg_alu_seq.sv
// reg_alu_seq: sequential register-file ALU with valid/ready issue, flags and debug read; REG_ALU_MUL_EN adds the iterative multiplier
module reg_alu_seq #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    output logic              done,
    output logic              illegal,
    output logic [3:0]        flags,
    input  logic [3:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_MUL = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_NOT = 4'h6;
    localparam logic [3:0] OP_SHL = 4'h7;
    localparam logic [3:0] OP_SHR = 4'h8;
    localparam logic [3:0] OP_SRA = 4'h9;
    localparam logic [3:0] OP_LDI = 4'hF;

`ifdef REG_ALU_MUL_EN
    typedef enum logic [1:0] {IDLE, EXEC, MUL} state_t;
    localparam int CW = $clog2(DATA_W) + 1;
`else
    typedef enum logic {IDLE, EXEC} state_t;
`endif

    state_t            state;
    logic [15:0]       ir;
    logic [DATA_W-1:0] regs [NREGS];
    logic [3:0]        op, ra, rb, rd;
    logic [DATA_W-1:0] a, b, res;
    logic [DATA_W:0]   sum;
    logic              c, v;

    function automatic logic idx_ok(input logic [3:0] idx);
        return 32'(idx) < NREGS;
    endfunction

    function automatic logic instr_ok(input logic [15:0] i);
        logic [3:0] o;
        o = i[15:12];
`ifdef REG_ALU_MUL_EN
        if (o > OP_SRA && o != OP_LDI) return 1'b0;
`else
        if ((o > OP_SRA && o != OP_LDI) || o == OP_MUL) return 1'b0;
`endif
        if (o == OP_LDI) return idx_ok(i[11:8]);
        if (o == OP_NOT) return idx_ok(i[11:8]) && idx_ok(i[3:0]);
        return idx_ok(i[11:8]) && idx_ok(i[7:4]) && idx_ok(i[3:0]);
    endfunction

    assign op          = ir[15:12];
    assign ra          = ir[11:8];
    assign rb          = ir[7:4];
    assign rd          = (op == OP_LDI) ? ir[11:8] : ir[3:0];
    assign a           = idx_ok(ra) ? regs[ra] : '0;
    assign b           = idx_ok(rb) ? regs[rb] : '0;
    assign dbg_data    = idx_ok(dbg_addr) ? regs[dbg_addr] : '0;
    assign instr_ready = (state == IDLE);

`ifdef REG_ALU_MUL_EN
    logic [DATA_W-1:0] mcand, mplier, acc, acc_nxt;
    logic [CW-1:0]     cnt;
    assign acc_nxt = mplier[0] ? acc + mcand : acc;
`endif

    // single-cycle ALU result, carry and overflow for the instruction held in IR
    always_comb begin
        sum = '0;
        c   = 1'b0;
        v   = 1'b0;
        res = '0;
        case (op)
            OP_ADD: begin
                sum = {1'b0, a} + {1'b0, b};
                res = sum[DATA_W-1:0];
                c   = sum[DATA_W];
                v   = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
            end
            OP_SUB: begin
                sum = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};
                res = sum[DATA_W-1:0];
                c   = sum[DATA_W];
                v   = (a[DATA_W-1] != b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
            end
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_NOT:  res = ~a;
            OP_SHL:  res = a << b[3:0];
            OP_SHR:  res = a >> b[3:0];
            OP_SRA:  res = $signed(a) >>> b[3:0];
            OP_LDI:  res = DATA_W'(ir[7:0]);
            default: res = '0;
        endcase
    end

    // issue FSM, register file writeback, flags and retire pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ir      <= '0;
            done    <= 1'b0;
            illegal <= 1'b0;
            flags   <= '0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
`ifdef REG_ALU_MUL_EN
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
`endif
        end else begin
            done    <= 1'b0;
            illegal <= 1'b0;
            case (state)
                IDLE: if (instr_valid) begin
                    ir <= instr;
`ifdef REG_ALU_MUL_EN
                    if (instr[15:12] == OP_MUL && instr_ok(instr)) begin
                        state  <= MUL;
                        mcand  <= regs[instr[11:8]];
                        mplier <= regs[instr[7:4]];
                        acc    <= '0;
                        cnt    <= '0;
                    end else begin
                        state  <= EXEC;
                    end
`else
                    state <= EXEC;
`endif
                end
                EXEC: begin
                    state <= IDLE;
                    done  <= 1'b1;
                    if (!instr_ok(ir)) begin
                        illegal <= 1'b1;
                    end else begin
                        regs[rd] <= res;
                        if (op != OP_LDI) flags <= {res == '0, res[DATA_W-1], c, v};
                    end
                end
`ifdef REG_ALU_MUL_EN
                MUL: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(DATA_W - 1)) begin
                        state         <= IDLE;
                        done          <= 1'b1;
                        regs[ir[3:0]] <= acc_nxt;
                        flags         <= {acc_nxt == '0, acc_nxt[DATA_W-1], 2'b00};
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_reg_alu_seq.sv
// tb_reg_alu_seq: random and directed instruction streams checked every cycle against an arithmetic reference model
module tb_reg_alu_seq;
    localparam int W = 16;
`ifdef REG_ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         instr_valid = 1'b0;
    logic         instr_ready;
    logic [15:0]  instr = '0;
    logic         done;
    logic         illegal;
    logic [3:0]   flags;
    logic [3:0]   dbg_addr = '0;
    logic [W-1:0] dbg_data;

    int tests = 0;
    int fails = 0;

    logic [W-1:0] m_regs [16];
    logic [3:0]   m_flags = '0;
    int ncyc = 0;
    int done_at = -1;
    int acc_n = 0;
    int last_lat = 0;
    int done_cnt = 0;
    int ill_cnt = 0;
    bit p_ill, p_wr, p_fupd;
    logic [3:0]   p_rd, p_fl;
    logic [W-1:0] p_val;

    reg_alu_seq #(.DATA_W(W), .NREGS(16)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr(instr),
        .done(done),
        .illegal(illegal),
        .flags(flags),
        .dbg_addr(dbg_addr),
        .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, ncyc);
        end
    endtask

    // reference semantics: decide the outcome of an instruction the moment it is accepted
    task automatic model_accept(input logic [15:0] i);
        logic [3:0]   op;
        logic [W-1:0] a, b, nb;
        int           sa, sb, sh, full, lim;
        longint       p;
        bit           c, v, known;
        op    = i[15:12];
        a     = m_regs[i[11:8]];
        b     = m_regs[i[7:4]];
        nb    = ~b;
        sa    = $signed(a);
        sb    = $signed(b);
        sh    = int'(b[3:0]);
        lim   = 1 << (W - 1);
        c     = 1'b0;
        v     = 1'b0;
        p_val = '0;
        p_rd  = i[3:0];
        p_fupd = 1'b1;
        known = (op <= 4'd9 && (MUL_EN || op != 4'd2)) || op == 4'hF;
        case (op)
            4'h0: begin
                full  = int'(a) + int'(b);
                p_val = W'(full);
                c     = full >= (1 << W);
                v     = (sa + sb) >= lim || (sa + sb) < -lim;
            end
            4'h1: begin
                full  = int'(a) + int'(nb) + 1;
                p_val = W'(full);
                c     = full >= (1 << W);
                v     = (sa - sb) >= lim || (sa - sb) < -lim;
            end
            4'h2: begin
                p     = longint'(a) * longint'(b);
                p_val = W'(p);
            end
            4'h3: p_val = a & b;
            4'h4: p_val = a | b;
            4'h5: p_val = a ^ b;
            4'h6: p_val = ~a;
            4'h7: begin
                p     = longint'(a) * (longint'(1) << sh);
                p_val = W'(p);
            end
            4'h8: p_val = W'(int'(a) / (1 << sh));
            4'h9: p_val = W'(sa >>> sh);
            4'hF: begin
                p_rd   = i[11:8];
                p_val  = W'(i[7:0]);
                p_fupd = 1'b0;
            end
            default: known = 1'b0;
        endcase
        p_ill = !known;
        p_wr  = known;
        if (!known) p_fupd = 1'b0;
        p_fl    = {p_val == '0, p_val[W-1], c, v};
        acc_n   = ncyc;
        done_at = ncyc + ((op == 4'h2 && MUL_EN) ? W + 1 : 2);
    endtask

    // per-cycle compare of every output against the model
    initial begin
        bit exp_done;
        forever begin
            @(negedge clk);
            #2;
            dbg_addr = 4'($urandom);
            #1;
            ncyc++;
            if (!rst_n) begin
                foreach (m_regs[k]) m_regs[k] = '0;
                m_flags = '0;
                done_at = -1;
                chk("rst_done", 32'(done), 0);
                chk("rst_illegal", 32'(illegal), 0);
                chk("rst_flags", 32'(flags), 0);
                chk("rst_dbg", 32'(dbg_data), 0);
            end else begin
                exp_done = (ncyc == done_at);
                if (exp_done) begin
                    if (p_wr) m_regs[p_rd] = p_val;
                    if (p_fupd) m_flags = p_fl;
                    done_at = -1;
                end
                chk("done", 32'(done), 32'(exp_done));
                chk("illegal", 32'(illegal), 32'(exp_done && p_ill));
                chk("instr_ready", 32'(instr_ready), 32'(done_at < 0));
                chk("flags", 32'(flags), 32'(m_flags));
                chk("dbg_data", 32'(dbg_data), 32'(m_regs[dbg_addr]));
                if (done) begin
                    done_cnt++;
                    last_lat = ncyc - acc_n;
                    if (illegal) ill_cnt++;
                end
                if (instr_valid && done_at < 0) model_accept(instr);
            end
        end
    end

    // present an instruction at a falling edge; returns at the falling edge after acceptance with valid still high
    task automatic issue(input logic [15:0] i);
        int k;
        k = 0;
        instr       = i;
        instr_valid = 1'b1;
        #1;
        while (!instr_ready && k < 50) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("accept_wait", 32'(k < 50), 1);
        @(negedge clk);
    endtask

    task automatic settle();
        int k;
        k = 0;
        instr_valid = 1'b0;
        while (done_at >= 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("retire_wait", 32'(k < 100), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, i0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        d0 = done_cnt;
        issue(16'hF17F);
        issue(16'hF201);
        issue(16'h0123);
        settle();
        chk("lit_add_r3", 32'(m_regs[3]), 32'h0080);
        chk("lit_add_flags", 32'(m_flags), 0);
        chk("lit_three_done", 32'(done_cnt - d0), 3);
        chk("lit_exec_latency", 32'(last_lat), 2);

        issue(16'hF100);
        issue(16'h6104);
        issue(16'h0445);
        settle();
        chk("lit_not_r4", 32'(m_regs[4]), 32'hFFFF);
        chk("lit_add_r5", 32'(m_regs[5]), 32'hFFFE);
        chk("lit_add_carry_flags", 32'(m_flags), 32'b0110);
        issue(16'h1116);
        settle();
        chk("lit_sub_r6", 32'(m_regs[6]), 0);
        chk("lit_sub_flags", 32'(m_flags), 32'b1010);

        issue(16'hF103);
        issue(16'h6002);
        i0 = ill_cnt;
        issue(16'h2127);
        settle();
        chk("lit_mul_r7", 32'(m_regs[7]), MUL_EN ? 32'hFFFD : 32'h0);
        chk("lit_mul_latency", 32'(last_lat), MUL_EN ? W + 1 : 2);
        chk("lit_mul_illegal", 32'(ill_cnt - i0), MUL_EN ? 0 : 1);

        issue(16'hF801);
        issue(16'hF90F);
        issue(16'h7894);
        settle();
        chk("lit_shl_r4", 32'(m_regs[4]), 32'h8000);
        chk("lit_shl_flags", 32'(m_flags), 32'b0100);
        issue(16'hFA04);
        issue(16'h84AC);
        issue(16'h94AB);
        settle();
        chk("lit_shr_r12", 32'(m_regs[12]), 32'h0800);
        chk("lit_sra_r11", 32'(m_regs[11]), 32'hF800);
        chk("lit_sra_flags", 32'(m_flags), 32'b0100);

        d0 = done_cnt;
        i0 = ill_cnt;
        issue(16'hC123);
        @(negedge clk);
        settle();
        chk("lit_illegal_pulse", 32'(ill_cnt - i0), 1);
        chk("lit_illegal_single_done", 32'(done_cnt - d0), 1);
        chk("lit_illegal_flags", 32'(m_flags), 32'b0100);
        chk("lit_illegal_r3", 32'(m_regs[3]), 32'h0080);

        issue(16'h2127);
        instr_valid = 1'b0;
        repeat (5) @(negedge clk);
        d0 = done_cnt;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 4) @(negedge clk);
        chk("lit_reset_no_done", 32'(done_cnt - d0), 0);
        chk("lit_reset_r7", 32'(m_regs[7]), 0);
        chk("lit_reset_flags", 32'(m_flags), 0);
        issue(16'hF105);
        settle();
        chk("lit_after_reset_r1", 32'(m_regs[1]), 5);

        for (int n = 0; n < 400; n++) begin
            issue({4'($urandom_range(0, 15)), 12'($urandom)});
            if ($urandom_range(0, 3) == 0) begin
                instr_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            if ($urandom_range(0, 99) == 0) begin
                instr_valid = 1'b0;
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
            end
        end
        settle();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
